// File: rtl/uart_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_arbiter
// Purpose  : Shares one UART transmitter between two byte requesters using
//            round-robin arbitration, and drains the UART receiver into a
//            registered byte/status pair with a one-cycle valid pulse.
// Ports    : clk16x, clrn (async active-low reset)
//            req0/req1, data0/data1 -> ack0/ack1   requester handshake
//            wrn, d_in, t_empty                    UART transmit side
//            rdn, d_out, r_ready, parity_error,
//            frame_error                           UART receive side
//            rx_valid, rx_data, rx_err             captured receive byte
//            tx_timeout                            sticky transmit timeout
// Revision : 1.0 - initial release
// ============================================================================
module uart_arbiter #(
  parameter int unsigned BUSY_TO = 16
) (
  input  logic       clk16x,
  input  logic       clrn,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       wrn,
  output logic [7:0] d_in,
  input  logic       t_empty,
  output logic       rdn,
  input  logic [7:0] d_out,
  input  logic       r_ready,
  input  logic       parity_error,
  input  logic       frame_error,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic [1:0] rx_err,
  output logic       tx_timeout
);

  // Final count value of the WAIT_BUSY window: timeout fires on the edge
  // that completes BUSY_TO cycles in that state.
  localparam logic [7:0] c_busy_last = 8'(BUSY_TO - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    WAIT_BUSY  = 2'd2,
    WAIT_EMPTY = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RIDLE = 2'd0,
    READ  = 2'd1,
    RWAIT = 2'd2
  } rx_state_t;

  tx_state_t  r_tx_state;
  rx_state_t  r_rx_state;
  logic [7:0] r_tx_cnt;
  logic       r_rx_cnt;
  logic       r_last_grant;
  logic       r_ack0;
  logic       r_ack1;
  logic       r_wrn;
  logic [7:0] r_d_in;
  logic       r_tx_timeout;
  logic       r_rdn;
  logic       r_rx_valid;
  logic [7:0] r_rx_data;
  logic [1:0] r_rx_err;
  logic       w_grant1;

  // Requester 1 wins when alone, or on a tie when requester 0 went last.
  assign w_grant1 = req1 & (~req0 | ~r_last_grant);

  // --------------------------------------------------------------------------
  // Transmit arbiter FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      r_tx_state   <= IDLE;
      r_tx_cnt     <= 8'd0;
      r_last_grant <= 1'b1;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_wrn        <= 1'b1;
      r_d_in       <= 8'd0;
      r_tx_timeout <= 1'b0;
    end else begin
      // Acks are single-cycle pulses raised only on the grant edge.
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_tx_state)
        IDLE: begin
          if (t_empty && (req0 || req1)) begin
            r_tx_state   <= WRITE;
            r_tx_cnt     <= 8'd0;
            r_wrn        <= 1'b0;
            r_last_grant <= w_grant1;
            r_d_in       <= w_grant1 ? data1 : data0;
            r_ack1       <= w_grant1;
            r_ack0       <= ~w_grant1;
          end
        end
        WRITE: begin
          if (r_tx_cnt == 8'd0) begin
            r_tx_cnt <= 8'd1;
          end else begin
            r_tx_cnt   <= 8'd0;
            r_wrn      <= 1'b1;
            r_tx_state <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!t_empty) begin
            r_tx_cnt   <= 8'd0;
            r_tx_state <= WAIT_EMPTY;
          end else if (r_tx_cnt == c_busy_last) begin
            r_tx_cnt     <= 8'd0;
            r_tx_timeout <= 1'b1;
            r_tx_state   <= IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 8'd1;
          end
        end
        WAIT_EMPTY: begin
          if (t_empty) begin
            r_tx_state <= IDLE;
          end
        end
        default: begin
          r_tx_state <= IDLE;
          r_wrn      <= 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Receive drain FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      r_rx_state <= RIDLE;
      r_rx_cnt   <= 1'b0;
      r_rdn      <= 1'b1;
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'd0;
      r_rx_err   <= 2'b00;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        RIDLE: begin
          if (r_ready) begin
            r_rx_state <= READ;
            r_rx_cnt   <= 1'b0;
            r_rdn      <= 1'b0;
          end
        end
        READ: begin
          if (!r_rx_cnt) begin
            r_rx_cnt <= 1'b1;
          end else begin
            // Capture on the edge closing the second strobe cycle, so the
            // valid pulse lines up with the freshly loaded data.
            r_rx_cnt   <= 1'b0;
            r_rdn      <= 1'b1;
            r_rx_data  <= d_out;
            r_rx_err   <= {frame_error, parity_error};
            r_rx_valid <= 1'b1;
            r_rx_state <= RWAIT;
          end
        end
        RWAIT: begin
          // Wait for the receiver to drop r_ready so a byte is read once.
          if (!r_ready) begin
            r_rx_state <= RIDLE;
          end
        end
        default: begin
          r_rx_state <= RIDLE;
          r_rdn      <= 1'b1;
        end
      endcase
    end
  end

  assign ack0       = r_ack0;
  assign ack1       = r_ack1;
  assign wrn        = r_wrn;
  assign d_in       = r_d_in;
  assign tx_timeout = r_tx_timeout;
  assign rdn        = r_rdn;
  assign rx_valid   = r_rx_valid;
  assign rx_data    = r_rx_data;
  assign rx_err     = r_rx_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_arbiter
// Purpose  : Directed self-checking bench for uart_arbiter: arbitration,
//            write/read strobe timing, busy timeout, reset abort and
//            concurrent transmit/receive.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_arbiter;

  localparam int unsigned BUSY_TO = 16;

  logic       clk16x;
  logic       clrn;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       ack0, ack1;
  logic       wrn;
  logic [7:0] d_in;
  logic       t_empty;
  logic       rdn;
  logic [7:0] d_out;
  logic       r_ready, parity_error, frame_error;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [1:0] rx_err;
  logic       tx_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  uart_arbiter #(.BUSY_TO(BUSY_TO)) dut (
    .clk16x       (clk16x),
    .clrn         (clrn),
    .req0         (req0),
    .req1         (req1),
    .data0        (data0),
    .data1        (data1),
    .ack0         (ack0),
    .ack1         (ack1),
    .wrn          (wrn),
    .d_in         (d_in),
    .t_empty      (t_empty),
    .rdn          (rdn),
    .d_out        (d_out),
    .r_ready      (r_ready),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_err       (rx_err),
    .tx_timeout   (tx_timeout)
  );

  initial clk16x = 1'b0;
  always #5 clk16x = ~clk16x;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk16x);
    #1;
  endtask

  // One complete transmit: grant edge, 2-cycle write, UART goes busy for
  // 'hold' cycles, then empties; ends with the arbiter back in IDLE.
  task automatic tx_cycle(input logic a1, input logic [7:0] d, input logic drop, input int hold);
    tick();
    check("grant_ack0", ack0, !a1);
    check("grant_ack1", ack1, a1);
    check("grant_wrn", wrn, 1'b0);
    check("grant_d_in", d_in, d);
    if (drop) begin
      if (a1) req1 = 1'b0; else req0 = 1'b0;
    end
    tick();
    check("write2_wrn", wrn, 1'b0);
    check("write2_acks", {ack0, ack1}, 2'b00);
    tick();
    check("post_write_wrn", wrn, 1'b1);
    t_empty = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("busy_no_ack", {ack0, ack1, wrn}, 3'b001);
    end
    t_empty = 1'b1;
    tick();
    check("empty_no_ack", {ack0, ack1}, 2'b00);
  endtask

  initial begin
    clrn = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    t_empty = 1'b1; d_out = 8'h00; r_ready = 1'b0;
    parity_error = 1'b0; frame_error = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_wrn", wrn, 1'b1);
    check("rst_rdn", rdn, 1'b1);
    check("rst_acks", {ack0, ack1}, 2'b00);
    check("rst_d_in", d_in, 8'h00);
    check("rst_rx", {rx_valid, rx_data, rx_err}, 11'h000);
    check("rst_timeout", tx_timeout, 1'b0);
    clrn = 1'b1;

    // Single write of A5; req1 also pending, first tie goes to req0.
    // req1 must stay unserved while the UART is busy.
    req0 = 1'b1; data0 = 8'hA5;
    req1 = 1'b1; data1 = 8'h77;
    tx_cycle(1'b0, 8'hA5, 1'b1, 3);
    tx_cycle(1'b1, 8'h77, 1'b1, 1);

    // Both held: alternation 11,22,11,22
    req0 = 1'b1; data0 = 8'h11;
    req1 = 1'b1; data1 = 8'h22;
    tx_cycle(1'b0, 8'h11, 1'b0, 1);
    tx_cycle(1'b1, 8'h22, 1'b0, 1);
    tx_cycle(1'b0, 8'h11, 1'b0, 1);
    tx_cycle(1'b1, 8'h22, 1'b0, 2);
    req0 = 1'b0; req1 = 1'b0;

    // t_empty stuck high: timeout BUSY_TO cycles after entering WAIT_BUSY
    req0 = 1'b1; data0 = 8'h5A;
    tick();
    check("to_grant_ack0", ack0, 1'b1);
    req0 = 1'b0;
    tick();
    tick();
    check("to_enter_wrn", wrn, 1'b1);
    check("to_enter_flag", tx_timeout, 1'b0);
    repeat (BUSY_TO - 1) tick();
    check("to_early_flag", tx_timeout, 1'b0);
    req1 = 1'b1; data1 = 8'hC3;
    tick();
    check("to_flag_set", tx_timeout, 1'b1);
    check("to_no_ack1", ack1, 1'b0);
    tx_cycle(1'b1, 8'hC3, 1'b1, 1);
    check("to_sticky", tx_timeout, 1'b1);

    // Receive 3C with parity error; r_ready held high afterwards
    d_out = 8'h3C; parity_error = 1'b1; frame_error = 1'b0; r_ready = 1'b1;
    tick();
    check("rx_rdn1", rdn, 1'b0);
    check("rx_valid_early", rx_valid, 1'b0);
    tick();
    check("rx_rdn2", rdn, 1'b0);
    tick();
    check("rx_rdn_end", rdn, 1'b1);
    check("rx_valid", rx_valid, 1'b1);
    check("rx_data", rx_data, 8'h3C);
    check("rx_err", rx_err, 2'b01);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rx_no_reread", {rx_valid, rdn}, 2'b01);
    end
    check("rx_data_hold", rx_data, 8'h3C);
    r_ready = 1'b0; parity_error = 1'b0;
    tick();

    // Reset during WRITE with req1 pending
    req0 = 1'b1; data0 = 8'h44;
    tick();
    check("rw_ack0", ack0, 1'b1);
    req0 = 1'b0; req1 = 1'b1; data1 = 8'h99;
    tick();
    check("rw_write2", wrn, 1'b0);
    #2 clrn = 1'b0;
    #1;
    check("rw_async_wrn", wrn, 1'b1);
    check("rw_async_acks", {ack0, ack1}, 2'b00);
    check("rw_async_timeout", tx_timeout, 1'b0);
    check("rw_async_d_in", d_in, 8'h00);
    tick();
    check("rw_hold_ack1", ack1, 1'b0);
    clrn = 1'b1;
    tx_cycle(1'b1, 8'h99, 1'b1, 1);

    // Grant and r_ready rise on the same edge
    req0 = 1'b1; data0 = 8'hE7;
    r_ready = 1'b1; d_out = 8'h81; parity_error = 1'b0; frame_error = 1'b1;
    tick();
    check("sim_ack0", ack0, 1'b1);
    check("sim_d_in", d_in, 8'hE7);
    check("sim_strobes1", {wrn, rdn}, 2'b00);
    req0 = 1'b0;
    tick();
    check("sim_strobes2", {wrn, rdn}, 2'b00);
    check("sim_ack_gone", ack0, 1'b0);
    tick();
    check("sim_strobes_end", {wrn, rdn}, 2'b11);
    check("sim_rx_valid", rx_valid, 1'b1);
    check("sim_rx_data", rx_data, 8'h81);
    check("sim_rx_err", rx_err, 2'b10);
    t_empty = 1'b0;
    tick();
    check("sim_rx_pulse_end", rx_valid, 1'b0);
    t_empty = 1'b1; r_ready = 1'b0;
    tick();
    tick();
    check("sim_final_idle", {wrn, rdn, ack0, ack1}, 4'b1100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_arbiter.md
UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 Parameter BUSY_TO, default 16, is the max clk16x cycles to wait for t_empty to fall after a write (range 2-255).
REQ-002 clk16x  in  1  baud*16 clock; all state changes on rising edge.
REQ-003 clrn  in  1  reset, asynchronous, active-low.
REQ-004 req0, req1  in  1 each  requester wants to send one byte; held until matching ack.
REQ-005 data0, data1  in  8 each  byte from requester 0/1; stable while req high.
REQ-006 ack0, ack1  out  1 each  one-cycle pulse, byte accepted by transmitter.
REQ-007 wrn  out  1  UART write strobe, active low.
REQ-008 d_in  out  8  byte to UART transmitter.
REQ-009 t_empty  in  1  UART transmitter empty.
REQ-010 rdn  out  1  UART read strobe, active low.
REQ-011 d_out  in  8  byte from UART receiver.
REQ-012 r_ready, parity_error, frame_error  in  1 each  UART receive status.
REQ-013 rx_valid  out  1  one-cycle pulse, rx_data/rx_err valid.
REQ-014 rx_data  out  8  captured receive byte.
REQ-015 rx_err  out  2  {frame_error, parity_error} captured with rx_data.
REQ-016 tx_timeout  out  1  sticky flag: t_empty failed to fall within BUSY_TO cycles.

Function -- transmit side
REQ-017 TX FSM states: IDLE, WRITE, WAIT_BUSY, WAIT_EMPTY.
REQ-018 IDLE: if t_empty=1 and any req, grant per round-robin, latch granted data into d_in, go WRITE.
REQ-019 Round-robin: single request always wins; both high -> grant the requester not granted last; after reset last-grant = 1 (req0 wins first tie).
REQ-020 WRITE: wrn=0 for exactly 2 cycles (counted in WRITE), ack of granted requester pulses in the first of them; then go WAIT_BUSY.
REQ-021 wrn=1 in every state other than WRITE; d_in holds last granted byte until next grant.
REQ-022 WAIT_BUSY: t_empty=0 -> WAIT_EMPTY; if BUSY_TO cycles elapse with t_empty=1, set tx_timeout and go IDLE.
REQ-023 WAIT_EMPTY: t_empty=1 -> IDLE; no timeout.
REQ-024 Requester dropping req before ack: request is ignored, no ack; requester already in WRITE still completes.
REQ-025 A requester is never acked twice for one grant; next grant earliest 1 cycle after return to IDLE.
REQ-026 tx_timeout clears only on reset.

Function -- receive side
REQ-027 RX FSM states: RIDLE, READ, RWAIT.
REQ-028 RIDLE: r_ready=1 -> READ.
REQ-029 READ: rdn=0 for exactly 2 cycles; on the second, capture d_out into rx_data and {frame_error, parity_error} into rx_err; rx_valid pulses the cycle after capture; go RWAIT.
REQ-030 RWAIT: r_ready=0 -> RIDLE; never re-reads the same byte.
REQ-031 rx_data/rx_err hold until next capture; no backpressure, consumer must sample on rx_valid.
REQ-032 TX and RX FSMs independent; simultaneous TX grant and RX read both proceed in the same cycle.

Reset
REQ-033 clrn=0 asynchronously forces: TX in IDLE, RX in RIDLE, wrn=1, rdn=1, ack0=ack1=0, rx_valid=0, d_in=0, rx_data=0, rx_err=0, tx_timeout=0, last-grant=1, counters=0.
REQ-034 Reset mid-WRITE or mid-READ aborts immediately; no ack or rx_valid is issued for the aborted transfer.
REQ-035 First grant occurs no earlier than the first rising edge after clrn deasserts.

Verification
REQ-036 req0=1, data0=8'hA5, t_empty=1 -> ack0 pulse, wrn low 2 cycles, d_in=8'hA5; model UART drops t_empty -> FSM waits for t_empty=1 before next grant.
REQ-037 req0=req1=1 held, data0=8'h11, data1=8'h22, four transfers -> d_in sequence 11,22,11,22; acks alternate.
REQ-038 t_empty stuck at 1 after write -> tx_timeout=1 exactly BUSY_TO cycles after entering WAIT_BUSY; FSM returns IDLE and serves the next request.
REQ-039 r_ready=1, d_out=8'h3C, parity_error=1, frame_error=0 -> rdn low 2 cycles, one rx_valid, rx_data=8'h3C, rx_err=2'b01; r_ready held high -> no second rx_valid.
REQ-040 clrn pulsed low during WRITE with req1 pending -> wrn=1 immediately, no ack1; after release, req1 is served with a fresh ack1.
REQ-041 TX grant and r_ready rising in the same cycle -> both complete with correct data, timings unchanged vs. the isolated cases.
